attention_score_mac: RTL and testbench

Parametrised successor to the single-lane attention score unit. Computes A[l][n][l2] = sat((Q[l][n]·K[l2][n]) >>> SCALE_SHIFT) for all query/key pairs. It uses P parallel multiply lanes along the embedding axis and has an optional causal mask that skips masked pairs. It sits between the Q/K projection stage and softmax, and drives the same packed A bus that softmax consumes.

---
 rtl/attn_pkg.sv | 28 ++
 rtl/attention_score_mac_if.sv | 26 ++
 rtl/attn_dot_acc.sv | 52 +++++
 rtl/attention_score_mac.sv | 173 +++++++++++++++++
 tb/tb_attention_score_mac.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention score MAC.
package attn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Accumulator width that holds E full-width products without overflow.
  function automatic int acc_width(input int dw, input int e);
    return 2 * dw + $clog2(e) + 1;
  endfunction

  // Clamp a signed value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] v_max;
    logic signed [63:0] v_min;
    v_max = (64'sd1 <<< (width - 1)) - 64'sd1;
    v_min = -(64'sd1 <<< (width - 1));
    if (value > v_max) return v_max;
    if (value < v_min) return v_min;
    return value;
  endfunction

endpackage

// File: rtl/attention_score_mac_if.sv
// Request/result bundle between the Q/K projection side and the score unit.
interface attention_score_mac_if #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8
);
  logic                           start;
  logic                           causal_en;
  logic [DATA_WIDTH*L*N*E-1:0]    Q_in;
  logic [DATA_WIDTH*L*N*E-1:0]    K_in;
  logic [DATA_WIDTH*L*N*L-1:0]    A_out;
  logic                           busy;
  logic                           done;
  logic                           out_valid;

  modport master (
    output start, causal_en, Q_in, K_in,
    input  A_out, busy, done, out_valid
  );

  modport slave (
    input  start, causal_en, Q_in, K_in,
    output A_out, busy, done, out_valid
  );
endinterface

// File: rtl/attn_dot_acc.sv
// P-lane dot-product accumulator with shift-and-saturate result.
module attn_dot_acc
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int P           = 2,
  parameter int ACC_W       = 36,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_acc_en,
  input  logic                         i_last,
  input  logic [P*DATA_WIDTH-1:0]      i_q,
  input  logic [P*DATA_WIDTH-1:0]      i_k,
  output logic signed [DATA_WIDTH-1:0] o_result
);

  logic signed [2*DATA_WIDTH-1:0] w_prod [P];
  logic signed [ACC_W-1:0]        w_sum;
  logic signed [ACC_W-1:0]        w_total;
  logic signed [ACC_W-1:0]        w_shifted;
  logic signed [ACC_W-1:0]        r_acc;

  for (genvar g = 0; g < P; g++) begin : g_lane
    assign w_prod[g] = (2*DATA_WIDTH)'($signed(i_q[g*DATA_WIDTH +: DATA_WIDTH])) *
                       (2*DATA_WIDTH)'($signed(i_k[g*DATA_WIDTH +: DATA_WIDTH]));
  end

  // Sum all lane products for this beat.
  always_comb begin
    w_sum = '0;
    for (int p = 0; p < P; p++) w_sum = w_sum + ACC_W'(w_prod[p]);
  end

  assign w_total   = r_acc + w_sum;
  assign w_shifted = w_total >>> SCALE_SHIFT;
  assign o_result  = DATA_WIDTH'(sat_signed(64'(w_shifted), DATA_WIDTH));

  // Accumulate within a pair; restart at zero once the pair's last block is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= i_last ? '0 : w_total;
    end
  end

endmodule

// File: rtl/attention_score_mac.sv
// Attention score unit: A[l][n][l2] = sat((Q[l][n].K[l2][n]) >>> SCALE_SHIFT).
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_IDLE    | waiting for start; A_out holds the last result
//  ST_LOAD    | capture Q/K, preset result array to the mask value
//  ST_COMPUTE | one e-block of one (l, n, l2) pair per cycle
//  ST_DONE    | publish result array to A_out, pulse done
module attention_score_mac
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int L           = 8,
  parameter int N           = 1,
  parameter int E           = 8,
  parameter int P           = 2,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  attention_score_mac_if.slave  bus
);

  localparam int EB    = E / P;
  localparam int ACC_W = acc_width(DATA_WIDTH, E);
  localparam int LW    = (L  > 1) ? $clog2(L)  : 1;
  localparam int NW    = (N  > 1) ? $clog2(N)  : 1;
  localparam int EBW   = (EB > 1) ? $clog2(EB) : 1;
  localparam int QW    = DATA_WIDTH * L * N * E;
  localparam int AW    = DATA_WIDTH * L * N * L;

  localparam logic [LW-1:0]         L_LAST   = LW'(L - 1);
  localparam logic [NW-1:0]         N_LAST   = NW'(N - 1);
  localparam logic [EBW-1:0]        EB_LAST  = EBW'(EB - 1);
  localparam logic [DATA_WIDTH-1:0] MASK_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_out_valid;
  logic                    r_causal;
  logic [QW-1:0]           r_q;
  logic [QW-1:0]           r_k;
  logic [AW-1:0]           r_res;
  logic [AW-1:0]           r_a_out;
  logic [LW-1:0]           r_l;
  logic [NW-1:0]           r_n;
  logic [LW-1:0]           r_l2;
  logic [EBW-1:0]          r_eb;

  logic                    w_eb_last;
  logic                    w_l2_last;
  logic                    w_n_last;
  logic                    w_l_last;
  logic                    w_final;
  logic [LW-1:0]           w_l2_max;
  int                      w_q_base;
  int                      w_k_base;
  int                      w_r_base;
  logic [P*DATA_WIDTH-1:0] w_q_blk;
  logic [P*DATA_WIDTH-1:0] w_k_blk;
  logic signed [DATA_WIDTH-1:0] w_result;

  // Causal runs stop each query row at the diagonal, so masked pairs cost no beats.
  assign w_l2_max  = r_causal ? r_l : L_LAST;
  assign w_eb_last = (r_eb == EB_LAST);
  assign w_l2_last = (r_l2 == w_l2_max);
  assign w_n_last  = (r_n == N_LAST);
  assign w_l_last  = (r_l == L_LAST);
  assign w_final   = w_eb_last && w_l2_last && w_n_last && w_l_last;

  // Bit offsets of the current Q block, K block and result slot.
  always_comb begin
    w_q_base = ((int'(r_l)  * N + int'(r_n)) * E + int'(r_eb) * P) * DATA_WIDTH;
    w_k_base = ((int'(r_l2) * N + int'(r_n)) * E + int'(r_eb) * P) * DATA_WIDTH;
    w_r_base = ((int'(r_l)  * N + int'(r_n)) * L + int'(r_l2)) * DATA_WIDTH;
  end

  assign w_q_blk = r_q[w_q_base +: P*DATA_WIDTH];
  assign w_k_blk = r_k[w_k_base +: P*DATA_WIDTH];

  attn_dot_acc #(
    .DATA_WIDTH  (DATA_WIDTH),
    .P           (P),
    .ACC_W       (ACC_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_dot (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state == ST_LOAD),
    .i_acc_en (r_state == ST_COMPUTE),
    .i_last   (w_eb_last),
    .i_q      (w_q_blk),
    .i_k      (w_k_blk),
    .o_result (w_result)
  );

  // Sequencer: accept, load, iterate e-block/l2/n/l, publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_causal    <= 1'b0;
      r_q         <= '0;
      r_k         <= '0;
      r_res       <= '0;
      r_a_out     <= '0;
      r_l         <= '0;
      r_n         <= '0;
      r_l2        <= '0;
      r_eb        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_LOAD;
            r_busy      <= 1'b1;
            r_causal    <= bus.causal_en;
            r_out_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_q     <= bus.Q_in;
          r_k     <= bus.K_in;
          // Every unmasked slot is overwritten during compute; masked ones keep this.
          r_res   <= {(L*N*L){MASK_VAL}};
          r_l     <= '0;
          r_n     <= '0;
          r_l2    <= '0;
          r_eb    <= '0;
          r_state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (w_eb_last) r_res[w_r_base +: DATA_WIDTH] <= w_result;
          if (!w_eb_last) begin
            r_eb <= r_eb + EBW'(1);
          end else begin
            r_eb <= '0;
            if (!w_l2_last) begin
              r_l2 <= r_l2 + LW'(1);
            end else begin
              r_l2 <= '0;
              if (!w_n_last) begin
                r_n <= r_n + NW'(1);
              end else begin
                r_n <= '0;
                r_l <= w_l_last ? '0 : r_l + LW'(1);
              end
            end
          end
          if (w_final) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_a_out     <= r_res;
          r_done      <= 1'b1;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.A_out     = r_a_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_attention_score_mac.sv
// Directed bench for attention_score_mac: default, scaled and P-sweep instances.
module tb_attention_score_mac;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: L=8, N=1, E=8, P=2, no shift.
  attention_score_mac_if #(.DATA_WIDTH(16), .L(8), .N(1), .E(8)) if_def();
  attention_score_mac #(.DATA_WIDTH(16), .L(8), .N(1), .E(8), .P(2), .SCALE_SHIFT(0))
    u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));

  // Same geometry with SCALE_SHIFT=3.
  attention_score_mac_if #(.DATA_WIDTH(16), .L(8), .N(1), .E(8)) if_sh();
  attention_score_mac #(.DATA_WIDTH(16), .L(8), .N(1), .E(8), .P(2), .SCALE_SHIFT(3))
    u_sh (.clk(clk), .rst_n(rst_n), .bus(if_sh));

  // Sweep: L=4, N=2, E=8, P = 1, 2, 4, 8 sharing one stimulus.
  logic          sw_start;
  logic          sw_causal;
  logic [1023:0] sw_q;
  logic [1023:0] sw_k;
  logic [511:0]  sw_a [4];
  logic [3:0]    sw_done;
  int            qv [64];
  int            kv [64];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    attention_score_mac_if #(.DATA_WIDTH(16), .L(4), .N(2), .E(8)) sw_if();
    assign sw_if.start     = sw_start;
    assign sw_if.causal_en = sw_causal;
    assign sw_if.Q_in      = sw_q;
    assign sw_if.K_in      = sw_k;
    assign sw_a[g]         = sw_if.A_out;
    assign sw_done[g]      = sw_if.done;
    attention_score_mac #(.DATA_WIDTH(16), .L(4), .N(2), .E(8), .P(1 << g), .SCALE_SHIFT(0))
      u_dut (.clk(clk), .rst_n(rst_n), .bus(sw_if));
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] fill64(input logic [15:0] v);
    return {64{v}};
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? if_def.done : if_sh.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if_def.busy : if_sh.busy;
  endfunction

  function automatic logic get_ov(input int sel);
    return (sel == 0) ? if_def.out_valid : if_sh.out_valid;
  endfunction

  function automatic longint get_a(input int sel, input int idx);
    logic signed [15:0] v;
    v = (sel == 0) ? if_def.A_out[idx*16 +: 16] : if_sh.A_out[idx*16 +: 16];
    return longint'(v);
  endfunction

  // One run on the default (sel=0) or shifted (sel=1) instance with latency checks.
  task automatic run_one(input int sel, input bit causal, input int t_beats,
                         input int glitch_at, input int rst_at, input string tag);
    int k;
    @(negedge clk);
    if (sel == 0) begin if_def.causal_en = causal; if_def.start = 1'b1; end
    else          begin if_sh.causal_en  = causal; if_sh.start  = 1'b1; end
    @(posedge clk); #1;
    if_def.start = 1'b0;
    if_sh.start  = 1'b0;
    check_val({tag, "_busy_rise"}, longint'(get_busy(sel)), 1);
    check_val({tag, "_ov_clear"}, longint'(get_ov(sel)), 0);
    k = 0;
    while (!get_done(sel) && k < t_beats + 8) begin
      @(posedge clk); #1;
      k++;
      if (sel == 0) if_def.start = (k == glitch_at);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_val({tag, "_rst_a"},    longint'(|if_def.A_out), 0);
        check_val({tag, "_rst_busy"}, longint'(if_def.busy), 0);
        check_val({tag, "_rst_done"}, longint'(if_def.done), 0);
        check_val({tag, "_rst_ov"},   longint'(if_def.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    check_val({tag, "_latency"},  k, 2 + t_beats);
    check_val({tag, "_busy_low"}, longint'(get_busy(sel)), 0);
    check_val({tag, "_ov_set"},   longint'(get_ov(sel)), 1);
    @(posedge clk); #1;
    check_val({tag, "_done_fall"}, longint'(get_done(sel)), 0);
    check_val({tag, "_ov_hold"},   longint'(get_ov(sel)), 1);
  endtask

  task automatic check_elems(input int sel, input bit causal, input longint v_in,
                             input longint v_mask, input string tag);
    for (int l = 0; l < 8; l++)
      for (int l2 = 0; l2 < 8; l2++)
        check_val($sformatf("%s_a%0d_%0d", tag, l, l2), get_a(sel, l * 8 + l2),
                  (causal && l2 > l) ? v_mask : v_in);
  endtask

  function automatic longint gold(input int l, input int n, input int l2, input bit c);
    longint s;
    if (c && l2 > l) return -32768;
    s = 0;
    for (int e = 0; e < 8; e++)
      s += longint'(qv[(l * 2 + n) * 8 + e]) * longint'(kv[(l2 * 2 + n) * 8 + e]);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic run_sweep(input bit causal, input string tag);
    int lat [4];
    int t_beats;
    logic signed [15:0] a;
    for (int i = 0; i < 64; i++) begin
      qv[i] = int'($urandom_range(0, 180)) - 90;
      kv[i] = int'($urandom_range(0, 180)) - 90;
      sw_q[i*16 +: 16] = 16'(qv[i]);
      sw_k[i*16 +: 16] = 16'(kv[i]);
    end
    @(negedge clk);
    sw_causal = causal;
    sw_start  = 1'b1;
    @(posedge clk); #1;
    sw_start = 1'b0;
    for (int g = 0; g < 4; g++) lat[g] = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) if (sw_done[g] && lat[g] < 0) lat[g] = k;
    end
    for (int g = 0; g < 4; g++) begin
      t_beats = causal ? 2 * 10 * (8 >> g) : 2 * 16 * (8 >> g);
      check_val($sformatf("%s_p%0d_latency", tag, 1 << g), lat[g], 2 + t_beats);
      for (int l = 0; l < 4; l++)
        for (int n = 0; n < 2; n++)
          for (int l2 = 0; l2 < 4; l2++) begin
            a = sw_a[g][((l * 2 + n) * 4 + l2) * 16 +: 16];
            check_val($sformatf("%s_p%0d_a%0d_%0d_%0d", tag, 1 << g, l, n, l2),
                      longint'(a), gold(l, n, l2, causal));
          end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if_def.start = 1'b0; if_def.causal_en = 1'b0; if_def.Q_in = '0; if_def.K_in = '0;
    if_sh.start  = 1'b0; if_sh.causal_en  = 1'b0; if_sh.Q_in  = '0; if_sh.K_in  = '0;
    sw_start = 1'b0; sw_causal = 1'b0; sw_q = '0; sw_k = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", longint'(if_def.busy), 0);
    check_val("reset_done", longint'(if_def.done), 0);
    check_val("reset_ov",   longint'(if_def.out_valid), 0);
    check_val("reset_a",    longint'(|if_def.A_out), 0);
    check_val("reset_sw_a", longint'(|sw_a[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All ones: each dot product is 8.
    if_def.Q_in = fill64(16'h0001); if_def.K_in = fill64(16'h0001);
    run_one(0, 1'b0, 256, -1, -1, "ones_nc");
    check_elems(0, 1'b0, 8, 0, "ones_nc");
    run_one(0, 1'b1, 144, -1, -1, "ones_c");
    check_elems(0, 1'b1, 8, -32768, "ones_c");

    // Saturation at both ends.
    if_def.Q_in = fill64(16'h7FFF); if_def.K_in = fill64(16'h7FFF);
    run_one(0, 1'b0, 256, -1, -1, "sat_pos");
    check_elems(0, 1'b0, 32767, 0, "sat_pos");
    if_def.K_in = fill64(16'h8000);
    run_one(0, 1'b0, 256, -1, -1, "sat_neg");
    check_elems(0, 1'b0, -32768, 0, "sat_neg");

    // SCALE_SHIFT=3: 8*256 >>> 3 = 256, and -24 >>> 3 = -3.
    if_sh.Q_in = fill64(16'd16); if_sh.K_in = fill64(16'd16);
    run_one(1, 1'b0, 256, -1, -1, "sh_pos");
    check_elems(1, 1'b0, 256, 0, "sh_pos");
    if_sh.Q_in = fill64(16'hFFFD); if_sh.K_in = fill64(16'h0001);
    run_one(1, 1'b0, 256, -1, -1, "sh_neg");
    check_elems(1, 1'b0, -3, 0, "sh_neg");

    // Start pulsed mid-compute must not disturb timing or results.
    if_def.Q_in = fill64(16'h0001); if_def.K_in = fill64(16'h0001);
    run_one(0, 1'b0, 256, 50, -1, "glitch");
    check_elems(0, 1'b0, 8, 0, "glitch");

    // Reset at beat 100 (edge t0+101), then a fresh run: 8 * 2 * 3 = 48.
    run_one(0, 1'b0, 256, -1, 101, "midrst");
    if_def.Q_in = fill64(16'd2); if_def.K_in = fill64(16'd3);
    run_one(0, 1'b0, 256, -1, -1, "after_rst");
    check_elems(0, 1'b0, 48, 0, "after_rst");

    // Parameter sweep against a straight dot-product model.
    run_sweep(1'b0, "sw_nc");
    run_sweep(1'b1, "sw_c");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
